// File: rtl/fft_input_reorder_buffer.sv
// fft_input_reorder_buffer
//   Ping-pong input buffer for the 64-point FFT. Samples arrive in natural
//   order on a valid/ready stream. Each complete frame is replayed in
//   bit-reversed order to the first butterfly stage. One bank fills while
//   the other drains. The output side is fully registered.
// Ports:
//   clk                       rising-edge clock
//   rst                       asynchronous reset, active low
//   in_valid/in_ready         input handshake; in_ready = !full[wr_bank]
//   in_re/in_im               input sample (two's complement)
//   out_valid/out_ready       output handshake
//   out_re/out_im             output sample (registered)
//   out_addr                  natural-order index of the sample (bitrev of read count)
//   out_last                  marks the 64th sample of a frame
module fft_input_reorder_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 64,
  parameter int LOG2N      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic [LOG2N-1:0]      out_addr,
  output logic                  out_last
);

  localparam int W = 2 * DATA_WIDTH;

  // Both banks live in one array; the bank select is the address MSB.
  logic [W-1:0]     mem [2*N];

  logic             wr_bank, rd_bank;
  logic [LOG2N-1:0] wr_cnt, rd_cnt;
  logic [1:0]       full;

  logic             wr_fire, wr_wrap;
  logic             load, rd_wrap;
  logic [LOG2N-1:0] rd_addr;
  logic [W-1:0]     rd_word;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  assign in_ready = !full[wr_bank];
  assign wr_fire  = in_valid && in_ready;
  assign wr_wrap  = wr_fire && (wr_cnt == LOG2N'(N-1));

  // Load whenever the output register is empty or is being consumed.
  assign load     = full[rd_bank] && (!out_valid || out_ready);
  assign rd_wrap  = load && (rd_cnt == LOG2N'(N-1));
  assign rd_addr  = bitrev(rd_cnt);
  assign rd_word  = mem[{rd_bank, rd_addr}];

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank, wr_cnt}] <= {in_re, in_im};
  end

  // Write side.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_wrap) wr_bank <= ~wr_bank;
    end
  end

  // Bank occupancy. A set and a clear in the same cycle always hit
  // different banks: the writer only fills an empty bank and the reader
  // only releases a full one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 2'b00;
    end else begin
      if (wr_wrap) full[wr_bank] <= 1'b1;
      if (rd_wrap) full[rd_bank] <= 1'b0;
    end
  end

  // Read side and registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_re    <= rd_word[W-1:DATA_WIDTH];
      out_im    <= rd_word[DATA_WIDTH-1:0];
      out_addr  <= rd_addr;
      out_last  <= (rd_cnt == LOG2N'(N-1));
      out_valid <= 1'b1;
      rd_cnt    <= rd_cnt + 1'b1;
      if (rd_wrap) rd_bank <= ~rd_bank;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_input_reorder_buffer.sv
// tb_fft_input_reorder_buffer
//   Directed sequence of scenarios driving fft_input_reorder_buffer. A
//   negedge monitor captures accepted input samples; each completed frame
//   is pushed to a queue in bit-reversed order and popped against every
//   output transfer. Output hold stability is checked whenever the output
//   is stalled.
module tb_fft_input_reorder_buffer;
  localparam int DW = 16;
  localparam int N  = 64;
  localparam int L  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_re, out_im;
  logic [L-1:0]  out_addr;
  logic          out_last;

  fft_input_reorder_buffer #(.DATA_WIDTH(DW), .N(N), .LOG2N(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_addr(out_addr), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [L-1:0]  addr;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t            q[$];
  logic [2*DW-1:0] fbuf [N];
  int              fcnt = 0;
  int              cyc = 0;
  int              pop_cnt = 0;
  int              win_start = -1;
  int              first_cyc = 0;
  int              last_cyc = 0;
  int              accepted = 0;
  int              kidx = 0;
  int              data_mode = 1;
  logic            hold_prev = 1'b0;
  logic            prev_v = 1'b0;
  exp_t            prev_o, cur, e, m;
  logic [L-1:0]    ra;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [L-1:0] brev(input logic [L-1:0] a);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) r[L-1-i] = a[i];
    return r;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      q.delete();
      fcnt      = 0;
      hold_prev = 1'b0;
    end else begin
      cur = {out_addr, out_re, out_im, out_last};
      if (hold_prev) chk("hold_stable", {prev_v, prev_o}, {out_valid, cur});
      if (in_valid && in_ready) begin
        fbuf[fcnt] = {in_re, in_im};
        fcnt++;
        if (fcnt == N) begin
          for (int r = 0; r < N; r++) begin
            ra     = brev(L'(r));
            m.addr = ra;
            m.re   = fbuf[ra][2*DW-1:DW];
            m.im   = fbuf[ra][DW-1:0];
            m.last = (r == N-1);
            q.push_back(m);
          end
          fcnt = 0;
        end
      end
      if (out_valid && out_ready) begin
        chk("output_expected", (q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_sample", cur, e);
          if (win_start >= 0) begin
            if (pop_cnt == win_start)       first_cyc = cyc;
            if (pop_cnt == win_start + 191) last_cyc  = cyc;
          end
          pop_cnt++;
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_o    = cur;
      prev_v    = out_valid;
    end
  end

  task automatic cycle(input bit v, input bit r);
    bit hs;
    in_valid  = v;
    out_ready = r;
    if (data_mode == 0) begin
      in_re = DW'(kidx % N);
      in_im = -in_re;
    end else begin
      in_re = DW'($urandom);
      in_im = DW'($urandom);
    end
    @(negedge clk);
    hs = v && in_ready;
    @(posedge clk); #1;
    if (hs) begin
      accepted++;
      kidx++;
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", (q.size() == 0 && !out_valid), 1);
  endtask

  int n, pop0;

  initial begin
    // Reset held with random inputs
    rst = 1'b0;
    repeat (5) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_re     = DW'($urandom);
      in_im     = DW'($urandom);
      @(posedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_regs", {out_re, out_im, out_addr, out_last}, 0);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // Single frame re=k, im=-k
    data_mode = 0; kidx = 0; accepted = 0;
    for (int i = 0; i < N; i++) cycle(1, 1);
    chk("t2_accepted", accepted, 64);
    chk("t2_valid_low_at_E", out_valid, 0);
    cycle(0, 1);
    chk("t2_valid_at_E1", out_valid, 1);
    chk("t2_first", {out_addr, out_re, out_im, out_last}, {6'd0, 16'd0, 16'd0, 1'b0});
    cycle(0, 1);
    chk("t2_second", {out_addr, out_re, out_im, out_last}, {6'd32, 16'd32, 16'hFFE0, 1'b0});
    cycle(0, 1);
    chk("t2_third", {out_addr, out_re, out_im}, {6'd16, 16'd16, 16'hFFF0});
    drain(200);

    // Three back-to-back frames
    data_mode = 1; accepted = 0; win_start = pop_cnt;
    for (int i = 0; i < 3*N; i++) cycle(1, 1);
    chk("t3_in_ready_never_dropped", accepted, 192);
    drain(300);
    chk("t3_no_bubbles", last_cyc - first_cyc, 191);
    win_start = -1;

    // Backpressure with out_ready low
    accepted = 0; pop0 = pop_cnt;
    for (int i = 0; i < 140; i++) cycle(1, 0);
    chk("t4_accepted_128", accepted, 128);
    chk("t4_in_ready_low", in_ready, 0);
    chk("t4_out_valid", out_valid, 1);
    chk("t4_out_addr_held", out_addr, 0);
    n = 0;
    while (accepted < 129 && n < 300) begin cycle(1, 1); n++; end
    chk("t4_129_accepted", accepted, 129);
    chk("t4_resume_after_frame1", pop_cnt - pop0, 64);
    n = 0;
    while (accepted < 3*N && n < 500) begin cycle(1, 1); n++; end
    chk("t4_stream_done", accepted, 192);
    drain(300);

    // Asynchronous reset mid-frame while reading
    accepted = 0;
    for (int i = 0; i < N + 20; i++) cycle(1, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_out_valid", out_valid, 0);
    chk("t5_async_out_regs", {out_re, out_im, out_addr, out_last}, 0);
    chk("t5_async_in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    accepted = 0;
    for (int i = 0; i < N; i++) cycle(1, 1);
    chk("t5_frame_accepted", accepted, 64);
    drain(200);

    // Random throttling on both sides over 20 frames
    accepted = 0; n = 0;
    while (accepted < 20*N && n < 20000) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n++;
    end
    chk("t6_all_accepted", accepted, 1280);
    drain(400);
    chk("t6_no_partial_frame", fcnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_input_reorder_buffer.md
Name: fft_input_reorder_buffer

Overview:
- Ping-pong input buffer at the head of the 64-point FFT pipeline.
- Accepts complex samples in natural order on a valid/ready stream and emits each 64-sample frame in bit-reversed order to the first butterfly stage.
- Two banks, so one frame is written while the previous frame is read.
- Output is fully registered, so it can drive the stage registers directly.

Parameters:
- DATA_WIDTH, 16, bits per real and per imaginary component (two's complement).
- N, 64, frame length in complex samples; must equal 2**LOG2N.
- LOG2N, 6, address width and bit-reversal width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  input sample valid.
- in_ready  output  1  buffer can accept a sample.
- in_re  input  DATA_WIDTH  input real part.
- in_im  input  DATA_WIDTH  input imaginary part.
- out_valid  output  1  output sample valid.
- out_ready  input  1  downstream accepts the sample.
- out_re  output  DATA_WIDTH  output real part.
- out_im  output  DATA_WIDTH  output imaginary part.
- out_addr  output  LOG2N  natural-order index of the sample, i.e. bitrev(read count).
- out_last  output  1  high with the 64th sample of a frame.

Behaviour:
- Storage: two banks of N complex words. Bank contents are not reset.
- State registers:
  - wr_bank, wr_cnt[LOG2N-1:0]
  - rd_bank, rd_cnt[LOG2N-1:0]
  - full[1:0]
  - output registers
- Reset (rst=0, asynchronous): all state registers clear immediately.
  - wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, full=00.
  - out_valid=0, out_re=0, out_im=0, out_addr=0, out_last=0.
  - in_ready=1 while rst=1 after release.
- in_ready = !full[wr_bank]. It is combinational from registers only and does not depend on in_valid.
- Write handshake (in_valid & in_ready at a clk edge):
  - bank[wr_bank][wr_cnt] <= {in_re, in_im}; wr_cnt increments.
  - When wr_cnt==N-1: full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- Output load condition: load = full[rd_bank] & (!out_valid | out_ready).
- On load:
  - out_re/out_im <= bank[rd_bank][bitrev(rd_cnt)].
  - out_addr <= bitrev(rd_cnt); out_last <= (rd_cnt==N-1); out_valid <= 1.
  - rd_cnt increments.
  - When rd_cnt==N-1: full[rd_bank] <= 0, rd_bank toggles, rd_cnt wraps to 0.
- If there is no load and out_ready=1, out_valid <= 0. While out_valid=1 and out_ready=0, all out_* hold stable.
- Latency: 64th write handshake at edge E sets full at E; the first output of that frame is valid after edge E+1.
- Throughput: one sample per clock on both sides when unthrottled.
- Simultaneous set/clear of the same full bit cannot occur: write and read always address opposite banks when a bank is full. If a write completes the same cycle a read releases a bank, both updates apply.
- Back-to-back frames: output streams continuously with no gap between frames when out_ready=1.
- Backpressure: with both banks full, in_ready=0 until the read side releases a bank. in_ready returns high the cycle after the releasing edge.
- Bit reversal: address bit i maps to bit LOG2N-1-i. Read order for N=64 is 0,32,16,48,8,40,...,63.
- No arithmetic is performed; data passes bit-exact.

Test Plan:
- Reset: hold rst=0 with random inputs -> out_valid=0, out_re=out_im=0, out_last=0. After release with no input, in_ready=1.
- Single frame, out_ready=1, in_re=k, in_im=-k for k=0..63 -> output order 0,32,16,48,8,40,24,56,... (out_re=out_addr, out_im=-out_addr). out_valid rises one edge after the 64th handshake; out_last high only with out_addr=63.
- Three frames back-to-back (192 consecutive handshakes), out_ready=1 -> in_ready never drops; 192 outputs with no bubbles; frames alternate banks with data intact.
- out_ready=0, stream 130 samples -> in_ready falls after sample 128, so only 128 are accepted; out_valid=1 holding out_addr=0 stable. Raising out_ready drains frame 1, then in_ready returns and sample 129 is accepted.
- Assert rst=0 asynchronously (mid-cycle) after 20 samples of frame 2 while frame 1 is being read -> outputs clear immediately. The next frame is written from address 0, read back in correct bit-reversed order with no stale frame-1 samples.
- Random in_valid/out_ready throttling (50%) over 20 frames -> scoreboard matches the bit-reversed reference; no data is lost or duplicated; out_* are stable whenever out_valid & !out_ready.
